// File: rtl/pipe_mux_n.sv
// N-input registered selector with stall (hold), flush (bubble) and safe out-of-range select handling.
// Optional select checker (sticky SelErr, saturating ErrCnt) enabled by defining PIPE_MUX_SELCHK_EN.
module pipe_mux_n #(
    parameter int                 DataBit  = 32,
    parameter int                 NumIn    = 6,
    parameter int                 SelBit   = 3,
    parameter logic [DataBit-1:0] ResetVal = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NumIn*DataBit-1:0] In,
    input  logic [SelBit-1:0]        Sel,
    input  logic                     InValid,
    input  logic                     Stall,
    input  logic                     Flush,
    output logic [DataBit-1:0]       Out,
    output logic                     OutValid
`ifdef PIPE_MUX_SELCHK_EN
    ,
    output logic                     SelErr,
    output logic [7:0]               ErrCnt
`endif
);

    logic [DataBit-1:0] pick;
    logic               sel_good;
    logic [DataBit-1:0] out_d, out_q;
    logic               vld_d, vld_q;

    // Compare against every legal index so an out-of-range Sel never slices past In.
    always_comb begin
        pick     = ResetVal;
        sel_good = 1'b0;
        for (int k = 0; k < NumIn; k++) begin
            if (Sel == SelBit'(k)) begin
                pick     = In[k*DataBit +: DataBit];
                sel_good = 1'b1;
            end
        end
    end

    always_comb begin
        out_d = out_q;
        vld_d = vld_q;
        if (Flush) begin
            out_d = ResetVal;
            vld_d = 1'b0;
        end else if (!Stall) begin
            if (sel_good) begin
                out_d = pick;
                vld_d = InValid;
            end else begin
                out_d = ResetVal;
                vld_d = 1'b0;
            end
        end
    end

    // Output stage register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q <= ResetVal;
            vld_q <= 1'b0;
        end else begin
            out_q <= out_d;
            vld_q <= vld_d;
        end
    end

    assign Out      = out_q;
    assign OutValid = vld_q;

`ifdef PIPE_MUX_SELCHK_EN
    logic       bad_cap;
    logic       err_d, err_q;
    logic [7:0] cnt_d, cnt_q;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Only a real capture of a valid instruction with a bad select counts as an error.
    always_comb begin
        bad_cap = !Flush && !Stall && !sel_good && InValid;
        err_d   = err_q | bad_cap;
        cnt_d   = bad_cap ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    assign SelErr = err_q;
    assign ErrCnt = cnt_q;
`endif

endmodule
